// File: rtl/ap_batch_sequencer.sv
// ap_batch_sequencer
// Host-side batch engine for the associative processor AP_s. One start pulse
// loads CELL_QUANT operand pairs into CAM columns A and B, launches the
// selected operation, waits for the AP completion interrupt and streams
// column C back out through a small result FIFO.
//
// Ports
//   CLK100MHZ, rst          clock, synchronous active-high reset
//   start, cmd_in, dir_in,  batch launch and its operation/direction/bank,
//   bank_in                 captured when start is seen in IDLE
//   opnd_valid/ready/a/b    operand pair stream (column A word, column B word)
//   res_valid/ready/data/   column C result stream, res_last marks the
//   res_last                result of the final row
//   busy, done, err         status: not idle, end-of-batch pulse, sticky timeout
//   ap_*                    registered AP_s control/data bus, ap_data_out and
//                           ap_state_irq come back from the AP
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high; valid never depends on ready.
module ap_batch_sequencer #(
  parameter int WORD_SIZE      = 8,
  parameter int CELL_QUANT     = 512,
  parameter int ADDR_W         = $clog2(CELL_QUANT + 1),
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           cmd_in,
  input  logic                 dir_in,
  input  logic                 bank_in,
  input  logic                 opnd_valid,
  output logic                 opnd_ready,
  input  logic [WORD_SIZE-1:0] opnd_a,
  input  logic [WORD_SIZE-1:0] opnd_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_SIZE-1:0] res_data,
  output logic                 res_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [WORD_SIZE-1:0] ap_data,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_sel_internal_col,
  output logic                 ap_mode,
  output logic [2:0]           ap_cmd,
  output logic                 ap_op_direction,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  input  logic                 ap_state_irq
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(CELL_QUANT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_B, S_LAUNCH, S_WAIT_IRQ, S_DRAIN, S_FINISH
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]    row;
  logic [WORD_SIZE-1:0] b_hold;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 irq_prev;
  logic                 issued_all;   // every row of column C has been read
  logic                 rd_last;      // tag of the read presented on ap_read_en
  logic                 bus_vld;      // ap_data_out carries read data this cycle
  logic                 bus_last;

  logic [WORD_SIZE-1:0] fifo_data [2];
  logic [1:0]           fifo_last;
  logic                 fifo_wp, fifo_rp;
  logic [1:0]           fifo_cnt;

  logic       opnd_hs, irq_rise, tmo_hit, pop, issue;
  logic [2:0] pend;

  assign opnd_ready = (state == S_WR_A);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);
  assign res_valid  = (fifo_cnt != 2'd0);
  assign res_data   = fifo_data[fifo_rp];
  assign res_last   = res_valid & fifo_last[fifo_rp];

  always_comb begin
    opnd_hs  = (state == S_WR_A) && opnd_valid;
    irq_rise = ap_state_irq && !irq_prev;
    tmo_hit  = (tmo_cnt == TMO_LAST);
    pop      = res_valid && res_ready;
    // Entries that will still be held (FIFO after this pop plus the reads
    // on their way); a new read is issued only while that stays below 2,
    // so the FIFO can never overflow even if the consumer stops forever.
    pend  = {1'b0, fifo_cnt} + {2'b00, ap_read_en} + {2'b00, bus_vld} - {2'b00, pop};
    issue = (state == S_DRAIN) && !issued_all && (pend < 3'd2);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_WR_A;
      S_WR_A:     if (opnd_hs) state_next = S_WR_B;
      S_WR_B:     state_next = (row == ROW_LAST) ? S_LAUNCH : S_WR_A;
      S_LAUNCH:   state_next = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (irq_rise)     state_next = S_DRAIN;
        else if (tmo_hit) state_next = S_FINISH;
      end
      S_DRAIN:    if (pop && res_last) state_next = S_FINISH;
      S_FINISH:   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state               <= S_IDLE;
      row                 <= '0;
      b_hold              <= '0;
      tmo_cnt             <= '0;
      irq_prev            <= 1'b0;
      issued_all          <= 1'b0;
      rd_last             <= 1'b0;
      bus_vld             <= 1'b0;
      bus_last            <= 1'b0;
      err                 <= 1'b0;
      ap_addr             <= '0;
      ap_data             <= '0;
      ap_write_en         <= 1'b0;
      ap_read_en          <= 1'b0;
      ap_sel_col          <= 2'd0;
      ap_sel_internal_col <= 1'b0;
      ap_mode             <= 1'b0;
      ap_cmd              <= 3'd0;
      ap_op_direction     <= 1'b0;
      fifo_data[0]        <= '0;
      fifo_data[1]        <= '0;
      fifo_last           <= 2'b00;
      fifo_wp             <= 1'b0;
      fifo_rp             <= 1'b0;
      fifo_cnt            <= 2'd0;
    end else begin
      state       <= state_next;
      irq_prev    <= ap_state_irq;
      ap_write_en <= 1'b0;
      ap_read_en  <= 1'b0;
      bus_vld     <= ap_read_en;
      bus_last    <= rd_last;

      case (state)
        S_IDLE: begin
          if (start) begin
            ap_cmd              <= cmd_in;
            ap_op_direction     <= dir_in;
            ap_sel_internal_col <= bank_in;
            err                 <= 1'b0;
            row                 <= '0;
          end
        end
        S_WR_A: begin
          if (opnd_hs) begin
            ap_write_en <= 1'b1;
            ap_sel_col  <= 2'd0;
            ap_addr     <= row;
            ap_data     <= opnd_a;
            b_hold      <= opnd_b;
          end
        end
        S_WR_B: begin
          ap_write_en <= 1'b1;
          ap_sel_col  <= 2'd1;
          ap_addr     <= row;
          ap_data     <= b_hold;
          if (row != ROW_LAST) row <= row + 1'b1;
        end
        S_LAUNCH: begin
          ap_sel_col <= 2'd0;
          ap_mode    <= 1'b1;
          tmo_cnt    <= '0;
        end
        S_WAIT_IRQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (irq_rise) begin
            ap_mode    <= 1'b0;
            row        <= '0;
            issued_all <= 1'b0;
          end else if (tmo_hit) begin
            ap_mode <= 1'b0;
            err     <= 1'b1;
          end
        end
        S_DRAIN: begin
          ap_sel_col <= 2'd2;
          if (issue) begin
            ap_read_en <= 1'b1;
            ap_addr    <= row;
            rd_last    <= (row == ROW_LAST);
            row        <= row + 1'b1;
            if (row == ROW_LAST) issued_all <= 1'b1;
          end
        end
        S_FINISH: ap_sel_col <= 2'd0;
        default: ;
      endcase

      // Read data appears on ap_data_out the cycle after ap_read_en.
      if (bus_vld) begin
        fifo_data[fifo_wp] <= ap_data_out;
        fifo_last[fifo_wp] <= bus_last;
        fifo_wp            <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, bus_vld} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ap_batch_sequencer.sv
module tb_ap_batch_sequencer;
  localparam int WS = 8, CQ = 8, AW = 4, TMO = 50, IRQ_DLY = 20;
  localparam int M_NORMAL = 0, M_TIMEOUT = 1, M_ABORT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, dir_in, bank_in, opnd_valid, opnd_ready, res_valid, res_ready, res_last;
  logic busy, done, err, ap_write_en, ap_read_en, ap_sel_internal_col, ap_mode, ap_op_direction;
  logic ap_state_irq;
  logic [2:0] cmd_in, ap_cmd;
  logic [1:0] ap_sel_col;
  logic [WS-1:0] opnd_a, opnd_b, res_data, ap_data, ap_data_out;
  logic [AW-1:0] ap_addr;

  ap_batch_sequencer #(.WORD_SIZE(WS), .CELL_QUANT(CQ), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK100MHZ(clk), .rst(rst), .start(start), .cmd_in(cmd_in), .dir_in(dir_in), .bank_in(bank_in),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done), .err(err), .ap_addr(ap_addr), .ap_data(ap_data),
    .ap_write_en(ap_write_en), .ap_read_en(ap_read_en), .ap_sel_col(ap_sel_col),
    .ap_sel_internal_col(ap_sel_internal_col), .ap_mode(ap_mode), .ap_cmd(ap_cmd),
    .ap_op_direction(ap_op_direction), .ap_data_out(ap_data_out), .ap_state_irq(ap_state_irq)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0, n_err = 0;
  logic [WS-1:0] exp_q[$];
  logic [7:0] cur_a[CQ], cur_b[CQ], cur_exp[CQ];
  logic [2:0] cur_cmd;
  logic cur_dir, cur_bank;
  int wr_cnt, rd_idx, res_idx, done_cnt, mode_cycles, resv_cnt;
  bit mon_en = 0;
  bit irq_en = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (c)
      3'd0: return a | b;
      3'd1: return a ^ b;
      3'd2: return a & b;
      3'd3: return ~a;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return p[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- behavioural AP model ----------------
  logic [7:0] col_a[16], col_b[16], col_c[16];
  bit mode_prev = 0;
  int irq_cd = 0;
  initial begin
    ap_state_irq = 1'b0;
    ap_data_out  = '0;
  end
  always @(posedge clk) begin
    if (ap_write_en && ap_sel_col == 2'd0) col_a[ap_addr] = ap_data;
    if (ap_write_en && ap_sel_col == 2'd1) col_b[ap_addr] = ap_data;
    if (ap_read_en && ap_sel_col == 2'd2) ap_data_out <= col_c[ap_addr];
    if (ap_mode && !mode_prev) irq_cd = IRQ_DLY;
    else if (ap_mode && irq_cd > 0) begin
      irq_cd--;
      if (irq_cd == 0 && irq_en) begin
        for (int r = 0; r < CQ; r++) col_c[r] = ref_op(ap_cmd, col_a[r], col_b[r]);
        ap_state_irq <= 1'b1;
      end
    end
    if (!ap_mode) ap_state_irq <= 1'b0;
    mode_prev = ap_mode;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (ap_write_en) begin
        if (wr_cnt < 2 * CQ) begin
          chk("wr_sel", 32'(ap_sel_col), 32'(wr_cnt % 2));
          chk("wr_addr", 32'(ap_addr), 32'(wr_cnt / 2));
          chk("wr_data", 32'(ap_data),
              32'((wr_cnt % 2) != 0 ? cur_b[wr_cnt / 2] : cur_a[wr_cnt / 2]));
        end else chk("wr_extra", 32'(wr_cnt), 32'(2 * CQ - 1));
        wr_cnt++;
      end
      if (ap_read_en) begin
        chk("rd_sel", 32'(ap_sel_col), 32'd2);
        chk("rd_addr", 32'(ap_addr), 32'(rd_idx));
        chk("outstanding_le2", 32'((rd_idx + 1 - res_idx) <= 2), 32'd1);
        rd_idx++;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("res_unexpected", 32'(res_idx), 32'(CQ));
        else chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
        chk("res_last", 32'(res_last), 32'(res_idx == CQ - 1));
        res_idx++;
      end
      if (ap_mode) begin
        mode_cycles++;
        chk("mode_latched", {28'd0, ap_cmd, ap_op_direction} , {28'd0, cur_cmd, cur_dir});
        chk("mode_bank", 32'(ap_sel_internal_col), 32'(cur_bank));
      end
      if (done) done_cnt++;
      if (res_valid) resv_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input bit gaps);
    for (int i = 0; i < CQ; i++) begin
      int w;
      if (gaps) begin
        opnd_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      opnd_valid = 1'b1;
      opnd_a = cur_a[i];
      opnd_b = cur_b[i];
      w = 0;
      while (!opnd_ready && w < 100) begin tick(); w++; end
      if (w >= 100) begin bound_fail("feed_handshake"); break; end
      tick();
    end
    opnd_valid = 1'b0;
    opnd_a = '0;
    opnd_b = '0;
  endtask

  task automatic consume(input int ready_mode);
    bit held = 0;
    int cyc = 0;
    while (!done && cyc < 1000) begin
      case (ready_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (res_idx == 3 && !held) begin
            held = 1;
            res_ready = 1'b0;
            repeat (10) tick();
          end
          res_ready = 1'(cyc % 2);
        end
      endcase
      tick();
      cyc++;
    end
    if (!done) bound_fail("wait_done");
    res_ready = 1'b1;
  endtask

  task automatic run_batch(input int mode, input int ready_mode, input bit gaps, input bit extra_start);
    int w;
    wr_cnt = 0; rd_idx = 0; res_idx = 0; done_cnt = 0; mode_cycles = 0; resv_cnt = 0;
    exp_q.delete();
    if (mode == M_NORMAL) for (int i = 0; i < CQ; i++) exp_q.push_back(cur_exp[i]);
    irq_en = (mode != M_TIMEOUT);
    start = 1'b1; cmd_in = cur_cmd; dir_in = cur_dir; bank_in = cur_bank;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_clear_on_start", 32'(err), 32'd0);
    if (extra_start) begin
      start = 1'b1; cmd_in = cur_cmd ^ 3'b111; dir_in = ~cur_dir; bank_in = ~cur_bank;
      tick();
      start = 1'b0;
    end
    if (mode == M_ABORT) begin
      feed(gaps);
      w = 0;
      while (!ap_mode && w < 50) begin tick(); w++; end
      if (!ap_mode) bound_fail("wait_mode");
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("abort_mode", 32'(ap_mode), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_res_valid", 32'(res_valid), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      repeat (30) tick();
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end else begin
      fork
        feed(gaps);
        consume(ready_mode);
      join
      repeat (2) tick();
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("write_count", 32'(wr_cnt), 32'(2 * CQ));
      chk("idle_after", 32'(busy), 32'd0);
      if (mode == M_TIMEOUT) begin
        chk("tmo_mode_cycles", 32'(mode_cycles), 32'(TMO));
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_no_results", 32'(resv_cnt), 32'd0);
        chk("tmo_no_reads", 32'(rd_idx), 32'd0);
      end else begin
        chk("result_count", 32'(res_idx), 32'(CQ));
        chk("read_count", 32'(rd_idx), 32'(CQ));
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("err_low", 32'(err), 32'd0);
      end
    end
  endtask

  // ---------------- test tables ----------------
  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] exp; } row_vec_t;
  typedef struct { logic [2:0] cmd; logic [7:0] a; logic [7:0] b; logic [7:0] exp; } op_vec_t;
  row_vec_t add_tab[CQ];
  op_vec_t  op_tab[7];

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    add_tab = '{'{8'd1, 8'd0, 8'd1}, '{8'd2, 8'd1, 8'd3}, '{8'd3, 8'd2, 8'd5}, '{8'd4, 8'd0, 8'd4},
                '{8'd5, 8'd1, 8'd6}, '{8'd6, 8'd2, 8'd8}, '{8'd7, 8'd0, 8'd7}, '{8'd8, 8'd1, 8'd9}};
    op_tab  = '{'{3'd5, 8'h10, 8'h20, 8'hF0}, '{3'd0, 8'h0C, 8'h0A, 8'h0E},
                '{3'd1, 8'h0C, 8'h0A, 8'h06}, '{3'd2, 8'h0C, 8'h0A, 8'h08},
                '{3'd3, 8'h0C, 8'h0A, 8'hF3}, '{3'd6, 8'h13, 8'h11, 8'h43},
                '{3'd4, 8'hF0, 8'h25, 8'h15}};

    rst = 1'b1; start = 1'b0; cmd_in = '0; dir_in = 1'b0; bank_in = 1'b0;
    opnd_valid = 1'b0; opnd_a = '0; opnd_b = '0; res_ready = 1'b1;
    repeat (3) tick();
    chk("rst_status", {23'd0, busy, done, err, opnd_ready, res_valid, res_last, ap_write_en, ap_read_en, ap_mode}, 32'd0);
    chk("rst_ap_bus", {11'd0, ap_addr, ap_data, ap_sel_col, ap_cmd, ap_op_direction, ap_sel_internal_col}, 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    rst = 1'b0;
    wr_cnt = 0;
    mon_en = 1;

    // operands offered while idle must not be taken
    opnd_valid = 1'b1; opnd_a = 8'hAA; opnd_b = 8'h55;
    repeat (3) begin
      chk("idle_opnd_ready", 32'(opnd_ready), 32'd0);
      tick();
    end
    opnd_valid = 1'b0;
    chk("idle_no_write", 32'(wr_cnt), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // ADD batch from the row table, with a second start pulse during WR_A
    cur_cmd = 3'd4; cur_dir = 1'b0; cur_bank = 1'b1;
    for (int i = 0; i < CQ; i++) begin
      cur_a[i] = add_tab[i].a; cur_b[i] = add_tab[i].b; cur_exp[i] = add_tab[i].exp;
    end
    run_batch(M_NORMAL, 0, 0, 1);

    // one batch per operation, same operands on every row
    for (int t = 0; t < 7; t++) begin
      cur_cmd = op_tab[t].cmd; cur_dir = 1'($urandom_range(0, 1)); cur_bank = 1'($urandom_range(0, 1));
      for (int i = 0; i < CQ; i++) begin
        cur_a[i] = op_tab[t].a; cur_b[i] = op_tab[t].b; cur_exp[i] = op_tab[t].exp;
      end
      run_batch(M_NORMAL, 1, 1, 0);
    end

    // toggling consumer with a 10-cycle stall mid-drain
    cur_cmd = 3'd4; cur_dir = 1'b1; cur_bank = 1'b0;
    for (int i = 0; i < CQ; i++) begin
      cur_a[i] = 8'(i * 16 + 3); cur_b[i] = 8'(i); cur_exp[i] = 8'(i * 17 + 3);
    end
    run_batch(M_NORMAL, 2, 0, 0);

    // AP never completes: timeout path, then err clears on the next start
    run_batch(M_TIMEOUT, 0, 0, 0);
    cur_cmd = 3'd1;
    for (int i = 0; i < CQ; i++) begin
      cur_a[i] = 8'(8'hA0 + i); cur_b[i] = 8'h0F; cur_exp[i] = 8'(8'hAF - i);
    end
    run_batch(M_NORMAL, 0, 0, 0);

    // reset in the middle of WAIT_IRQ, then a fresh batch
    run_batch(M_ABORT, 0, 0, 0);

    for (int n = 0; n < 5; n++) begin
      cur_cmd = 3'($urandom_range(0, 6)); cur_dir = 1'($urandom_range(0, 1)); cur_bank = 1'($urandom_range(0, 1));
      for (int i = 0; i < CQ; i++) begin
        cur_a[i] = 8'($urandom); cur_b[i] = 8'($urandom);
        cur_exp[i] = ref_op(cur_cmd, cur_a[i], cur_b[i]);
      end
      run_batch(M_NORMAL, 1, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
